keypad_scan: RTL and testbench
==============================

# keypad_scan

Matrix-keypad front end for the counter board. It scans a 4×4 active-low key matrix, debounces presses and releases, and emits a 4-bit key code with a one-cycle strobe. The code and strobe feed the counters' `D` and `load` inputs in place of slide switches, so this block is the input end of the path that the 7-segment drivers close on the output side.

## Interface
Parameters:
- `SCAN_DIV`, default 50000: clock cycles per column dwell (1 ms at 50 MHz); minimum 4.
- `DEB_CNT`, default 20: consecutive matching samples required to accept a press or a release; minimum 1.

Ports:
- `clk_50MHz` input 1: the only clock. All logic is on the rising edge.
- `R` input 1: reset, synchronous and active-low.
- `row` input 4: matrix rows, active-low, externally pulled up, asynchronous to the clock.
- `col` output 4: column drive, active-low one-hot. Undriven columns are high.
- `code` output 4: last accepted key, `{row_idx[1:0], col_idx[1:0]}`.
- `valid` output 1: one-cycle pulse when `code` updates.
- `held` output 1: level, high while the accepted key is down.

## Operation
- `row` passes through a 2-flop synchronizer. Every use of rows below refers to the synchronized value.
- Tick: a divider counts 0..SCAN_DIV-1. The sample point is the cycle where the divider is at SCAN_DIV-1.
- States: SCAN, DEBOUNCE, HELD, RELEASE.
- SCAN:
  - `col` is driven from `col_idx`; `col_idx` increments modulo 4 at every tick.
  - At a tick, if any row is low, capture `col_idx` and the row index. The lowest row index wins if several rows are low.
  - Then set the debounce count to 1, freeze `col_idx`, and go to DEBOUNCE.
- DEBOUNCE:
  - At each tick, test the captured row bit.
  - If it is low, increment the count. When the count reaches DEB_CNT, load `code`, pulse `valid`, set `held`, and go to HELD.
  - If it is high (bounce), clear the count and return to SCAN. `col_idx` advances at that tick.
  - With DEB_CNT=1, the press is accepted directly at the SCAN detection tick.
- HELD:
  - The column stays frozen. Only the captured row bit is watched; other keys are ignored.
  - A tick with that bit high sets the release count to 1 and moves to RELEASE.
- RELEASE:
  - At each tick, a high bit increments the release count and a low bit returns to HELD with the count cleared.
  - When the count reaches DEB_CNT, clear `held`, return to SCAN, and advance `col_idx` at that tick.
- `code` holds its value until the next accepted press. A new press of the same key re-pulses `valid`.
- Reset: when `R` is low at a clock edge, every register takes its reset value in that cycle, whatever state or count was in progress.

## Timing
- Reset values:
  - `col`=4'b1110
  - `col_idx`=0
  - `code`=4'h0
  - `valid`=0
  - `held`=0
  - state SCAN
  - divider, debounce count and release count all 0
  - synchronizer flops 4'b1111
- `col` changes only on the cycle after a tick.
- Row-to-sample latency is 2 cycles (synchronizer). The board must settle the matrix within SCAN_DIV-2 cycles of a column change.
- Press latency: `valid` and `held` rise on the cycle after the tick that reaches DEB_CNT. Measured from stable rows, the worst case is 2 + 4·SCAN_DIV + (DEB_CNT-1)·SCAN_DIV + 1 cycles.
- Release latency: `held` falls on the cycle after the DEB_CNT-th consecutive high sample.
- `valid` is exactly one cycle wide and never asserts in SCAN or RELEASE.
- Simultaneous press on two rows of one column: the lowest row is reported, and one `valid` pulse is produced.

## Structure
- Shared package `keypad_pkg` holds:
  - the state encoding constants (SCAN=2'd0, DEBOUNCE=2'd1, HELD=2'd2, RELEASE=2'd3);
  - `KEY_W`=4 and `MAT_N`=4.
  - Divider and count widths are derived with `$clog2(SCAN_DIV)` and `$clog2(DEB_CNT+1)`.
- One sub-module, `sync_2ff`: a 4-bit two-flop synchronizer, reset to all ones.
- The FSM, divider and counters are inline in `keypad_scan`.

## Test plan
All scenarios use SCAN_DIV=4 and DEB_CNT=3. The bench models the matrix: a pressed key (r,c) pulls `row[r]` low whenever `col[c]` is low.
- Reset: hold `R`=0 for 3 cycles with random `row`. Required: `col`=1110, `code`=0, `valid`=0, `held`=0. After release, `col` steps 1110→1101→1011→0111→1110 every 4 cycles.
- Clean press of key (2,1): exactly one `valid` pulse with `code`=4'h9. `held` rises in the same cycle as `valid`. Releasing the key drops `held` 3 ticks later.
- Bounce: key (1,3) is pressed for 1 tick and then released for 1 tick, repeated 4 times. Required: no `valid`, and scanning resumes after each bounce. A final stable press yields `code`=4'h7.
- Two keys (0,2) and (3,2) are pressed together: one `valid` with `code`=4'h2. While held, additionally pressing (1,0) produces no `valid`.
- Release glitch: in RELEASE, the row goes low for 1 tick. Required: `held` stays 1, and a full 3 high ticks are needed before it falls.
- Reset mid-operation: assert `R`=0 while in DEBOUNCE with count 2. Required: everything returns to reset values, with no `valid` produced.

Source files
------------

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared state encoding, matrix sizes and row-priority helper for keypad_scan
package keypad_pkg;

    localparam int KEY_W = 4;
    localparam int MAT_N = 4;
    localparam int IDX_W = $clog2(MAT_N);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    // Index of the lowest active-low row; only meaningful when some row is low.
    function automatic logic [IDX_W-1:0] lowest_low(input logic [MAT_N-1:0] rows);
        lowest_low = '0;
        for (int i = MAT_N - 1; i >= 0; i--) begin
            if (!rows[i]) begin
                lowest_low = IDX_W'(i);
            end
        end
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for the asynchronous row inputs, resets to all ones
module sync_2ff #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         resetn_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            meta_q <= '1;
            sync_q <= '1;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - 4x4 active-low matrix scanner with press/release debounce and code strobe
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int DEB_CNT  = 20
) (
    input  logic             clk_50MHz,
    input  logic             R,
    input  logic [MAT_N-1:0] row,
    output logic [MAT_N-1:0] col,
    output logic [KEY_W-1:0] code,
    output logic             valid,
    output logic             held
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEB_CNT + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_TGT  = CNT_W'(DEB_CNT);

    logic [MAT_N-1:0] row_s;
    logic [DIV_W-1:0] div_q;
    state_t           state_q, state_d;
    logic [IDX_W-1:0] col_idx_q, col_idx_d;
    logic [IDX_W-1:0] row_idx_q, row_idx_d;
    logic [CNT_W-1:0] deb_q, deb_d;
    logic [CNT_W-1:0] rel_q, rel_d;
    logic [KEY_W-1:0] code_q, code_d;
    logic             valid_q, valid_d;
    logic             held_q, held_d;

    logic tick;
    logic row_hit;
    logic any_low;

    sync_2ff #(.W(MAT_N)) u_row_sync (
        .clk_i    (clk_50MHz),
        .resetn_i (R),
        .d_i      (row),
        .q_o      (row_s)
    );

    assign tick    = (div_q == DIV_LAST);
    assign row_hit = !row_s[row_idx_q];
    assign any_low = !(&row_s);

    always_ff @(posedge clk_50MHz) begin
        if (!R) begin
            div_q     <= '0;
            state_q   <= SCAN;
            col_idx_q <= '0;
            row_idx_q <= '0;
            deb_q     <= '0;
            rel_q     <= '0;
            code_q    <= '0;
            valid_q   <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            div_q     <= tick ? '0 : div_q + DIV_W'(1);
            state_q   <= state_d;
            col_idx_q <= col_idx_d;
            row_idx_q <= row_idx_d;
            deb_q     <= deb_d;
            rel_q     <= rel_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            held_q    <= held_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        col_idx_d = col_idx_q;
        row_idx_d = row_idx_q;
        deb_d     = deb_q;
        rel_d     = rel_q;
        code_d    = code_q;
        valid_d   = 1'b0;
        held_d    = held_q;
        if (tick) begin
            case (state_q)
                SCAN: begin
                    if (any_low) begin
                        row_idx_d = lowest_low(row_s);
                        if (DEB_CNT == 1) begin
                            code_d  = {lowest_low(row_s), col_idx_q};
                            valid_d = 1'b1;
                            held_d  = 1'b1;
                            state_d = HELD;
                        end else begin
                            deb_d   = CNT_W'(1);
                            state_d = DEBOUNCE;
                        end
                    end else begin
                        col_idx_d = col_idx_q + IDX_W'(1);
                    end
                end
                DEBOUNCE: begin
                    if (row_hit) begin
                        if (deb_q + CNT_W'(1) == CNT_TGT) begin
                            code_d  = {row_idx_q, col_idx_q};
                            valid_d = 1'b1;
                            held_d  = 1'b1;
                            deb_d   = '0;
                            state_d = HELD;
                        end else begin
                            deb_d = deb_q + CNT_W'(1);
                        end
                    end else begin
                        deb_d     = '0;
                        col_idx_d = col_idx_q + IDX_W'(1);
                        state_d   = SCAN;
                    end
                end
                HELD: begin
                    // Column stays frozen, so only the captured key can affect row_hit.
                    if (!row_hit) begin
                        if (DEB_CNT == 1) begin
                            held_d    = 1'b0;
                            col_idx_d = col_idx_q + IDX_W'(1);
                            state_d   = SCAN;
                        end else begin
                            rel_d   = CNT_W'(1);
                            state_d = RELEASE;
                        end
                    end
                end
                RELEASE: begin
                    if (row_hit) begin
                        rel_d   = '0;
                        state_d = HELD;
                    end else if (rel_q + CNT_W'(1) == CNT_TGT) begin
                        rel_d     = '0;
                        held_d    = 1'b0;
                        col_idx_d = col_idx_q + IDX_W'(1);
                        state_d   = SCAN;
                    end else begin
                        rel_d = rel_q + CNT_W'(1);
                    end
                end
                default: state_d = SCAN;
            endcase
        end
    end

    assign col   = ~(MAT_N'(1) << col_idx_q);
    assign code  = code_q;
    assign valid = valid_q;
    assign held  = held_q;

endmodule

// File: tb/tb_keypad_scan.sv
// tb/tb_keypad_scan.sv - scoreboard bench for keypad_scan driving a modelled 4x4 key matrix
module tb_keypad_scan;

    localparam int SCAN_DIV = 4;
    localparam int DEB_CNT  = 3;

    logic        clk_50MHz = 1'b0;
    logic        R;
    logic [3:0]  row;
    logic [3:0]  col;
    logic [3:0]  code;
    logic        valid;
    logic        held;

    logic [15:0] pressed;
    logic        rand_en;
    logic [3:0]  rand_row;
    logic [3:0]  model_row;
    logic [1:0]  tb_div;
    logic [3:0]  exp_q[$];
    logic [3:0]  exp_code;
    logic [3:0]  exp_col;
    logic        prev_valid = 1'b0;
    logic        prev_held  = 1'b0;
    int          n_checks   = 0;
    int          n_fail     = 0;

    always #5 clk_50MHz = ~clk_50MHz;

    keypad_scan #(.SCAN_DIV(SCAN_DIV), .DEB_CNT(DEB_CNT)) dut (
        .clk_50MHz (clk_50MHz),
        .R         (R),
        .row       (row),
        .col       (col),
        .code      (code),
        .valid     (valid),
        .held      (held)
    );

    // A pressed key (r,c) pulls row r low while column c is driven low.
    always_comb begin
        model_row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !col[c]) begin
                    model_row[r] = 1'b0;
                end
            end
        end
        row = rand_en ? rand_row : model_row;
    end

    // Free-running scan phase: tb_div==0 at a negedge means the previous edge was a tick.
    always @(posedge clk_50MHz) begin
        if (!R) tb_div <= 2'd0;
        else    tb_div <= tb_div + 2'd1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk_50MHz) begin
        if (valid === 1'b1) begin
            check("valid_one_cycle", {31'd0, prev_valid}, 0);
            check("held_low_before_valid", {31'd0, prev_held}, 0);
            check("held_with_valid", {31'd0, held}, 1);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_valid: got code %0h expected no strobe", code);
            end else begin
                exp_code = exp_q.pop_front();
                check("valid_code", {28'd0, code}, {28'd0, exp_code});
            end
        end
        prev_valid = valid;
        prev_held  = held;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk_50MHz);
    endtask

    task automatic press(input int r, input int c);
        pressed[r*4+c] = 1'b1;
    endtask

    task automatic lift(input int r, input int c);
        pressed[r*4+c] = 1'b0;
    endtask

    task automatic wait_col(input logic [3:0] target, input int budget, input string name);
        int n = 0;
        while (!(col === target && tb_div == 2'd0) && n < budget) begin
            @(negedge clk_50MHz);
            n++;
        end
        check(name, {31'd0, (col === target && tb_div == 2'd0)}, 1);
    endtask

    task automatic wait_held(input logic lvl, input int budget, input string name);
        int n = 0;
        while (held !== lvl && n < budget) begin
            @(negedge clk_50MHz);
            n++;
        end
        check(name, {31'd0, held}, {31'd0, lvl});
    endtask

    initial begin
        R        = 1'b0;
        pressed  = '0;
        rand_en  = 1'b1;
        rand_row = 4'hF;

        repeat (3) begin
            rand_row = 4'($urandom);
            @(negedge clk_50MHz);
            check("reset_col", {28'd0, col}, 32'hE);
            check("reset_code", {28'd0, code}, 0);
            check("reset_valid", {31'd0, valid}, 0);
            check("reset_held", {31'd0, held}, 0);
        end
        R       = 1'b1;
        rand_en = 1'b0;
        for (int i = 0; i <= 16; i++) begin
            exp_col = 4'b0001 << ((i / 4) % 4);
            exp_col = ~exp_col;
            check("scan_col_step", {28'd0, col}, {28'd0, exp_col});
            @(negedge clk_50MHz);
        end

        // Clean press of (2,1), then a release aligned to a tick.
        exp_q.push_back(4'h9);
        press(2, 1);
        wait_held(1'b1, 60, "press21_held");
        while (tb_div != 2'd0) @(negedge clk_50MHz);
        lift(2, 1);
        step(11);
        check("release21_still_held", {31'd0, held}, 1);
        step(1);
        check("release21_dropped", {31'd0, held}, 0);

        // Bounce on (1,3): one tick low, one tick high, four times.
        for (int b = 0; b < 4; b++) begin
            wait_col(4'b0111, 20, "bounce_reach_col3");
            press(1, 3);
            step(4);
            lift(1, 3);
            wait_col(4'b1110, 8, "bounce_scan_resumes");
            check("bounce_no_held", {31'd0, held}, 0);
        end
        exp_q.push_back(4'h7);
        wait_col(4'b0111, 20, "stable13_reach_col3");
        press(1, 3);
        wait_held(1'b1, 40, "stable13_held");
        lift(1, 3);
        wait_held(1'b0, 40, "stable13_released");

        // Two rows in one column, then an extra key in another column while held.
        exp_q.push_back(4'h2);
        press(0, 2);
        press(3, 2);
        wait_held(1'b1, 60, "dual_held");
        press(1, 0);
        step(40);
        check("dual_still_held", {31'd0, held}, 1);
        check("dual_code_kept", {28'd0, code}, 32'h2);
        pressed = '0;
        wait_held(1'b0, 40, "dual_released");

        // Release glitch on (3,3): one low tick inside RELEASE restarts the count.
        exp_q.push_back(4'hF);
        press(3, 3);
        wait_held(1'b1, 60, "glitch_held");
        while (tb_div != 2'd0) @(negedge clk_50MHz);
        lift(3, 3);
        step(4);
        check("glitch_in_release_held", {31'd0, held}, 1);
        press(3, 3);
        step(4);
        check("glitch_back_held", {31'd0, held}, 1);
        lift(3, 3);
        step(11);
        check("glitch_full_count_needed", {31'd0, held}, 1);
        step(1);
        check("glitch_finally_dropped", {31'd0, held}, 0);

        // Reset while in DEBOUNCE with count 2.
        wait_col(4'b1110, 20, "midreset_reach_col0");
        press(2, 0);
        step(8);
        check("midreset_not_yet_held", {31'd0, held}, 0);
        R = 1'b0;
        lift(2, 0);
        step(2);
        check("midreset_col", {28'd0, col}, 32'hE);
        check("midreset_code", {28'd0, code}, 0);
        check("midreset_valid", {31'd0, valid}, 0);
        check("midreset_held", {31'd0, held}, 0);
        R = 1'b1;
        step(20);
        check("midreset_idle_held", {31'd0, held}, 0);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
